// File: rtl/tdm_pkg.sv
// Shared definitions for the 16-channel TDM mux/demux pair.
package tdm_pkg;
  localparam int N_CH  = 16;
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear-to-0, load-to-1 and wrapping increment.
module tdm_slot_counter #(
  parameter int N_CH  = tdm_pkg::N_CH,
  parameter int SEL_W = tdm_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load1,
  input  logic             clr,
  output logic [SEL_W-1:0] cnt
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SEL_W'(1);
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + SEL_W'(1);
    end
  end
endmodule

// File: rtl/tdm_demux_16.sv
// TDM receiver: locks on frame sync, assembles serial slots into a parallel word.
module tdm_demux_16
  import tdm_pkg::*;
#(
  parameter int N_CH  = tdm_pkg::N_CH,
  parameter int SEL_W = tdm_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             fs,
  output logic [N_CH-1:0]  o,
  output logic             valid,
  output logic             frame_err,
  output logic             locked,
  output logic [SEL_W-1:0] sel
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  state_t          state;
  logic [N_CH-1:0] staging;
  logic            at_slot0;
  logic            start_hit;
  logic            early_sync;
  logic            miss_sync;
  logic            normal;

  assign at_slot0   = (sel == '0);
  assign start_hit  = en && (state == HUNT) && fs;
  assign early_sync = en && (state == RUN) && fs && !at_slot0;
  assign miss_sync  = en && (state == RUN) && !fs && at_slot0;
  assign normal     = en && (state == RUN) && !early_sync && !miss_sync;
  assign locked     = (state == RUN);

  tdm_slot_counter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (normal),
    .load1 (start_hit || early_sync),
    .clr   (miss_sync),
    .cnt   (sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      staging   <= '0;
      o         <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (start_hit || early_sync) begin
        // A sync bit always restarts the frame at slot 0.
        staging[0] <= d;
        state      <= RUN;
        frame_err  <= early_sync;
      end else if (miss_sync) begin
        state     <= HUNT;
        frame_err <= 1'b1;
      end else if (normal) begin
        staging[sel] <= d;
        if (sel == LAST) begin
          o     <= {d, staging[N_CH-2:0]};
          valid <= 1'b1;
        end
      end
    end
  end
endmodule
